hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage RV32 core. Decides each cycle whether the front end advances, stalls on a load-use hazard, flushes on a taken branch, bubbles on an instruction-fetch miss, or freezes the whole pipe on a data-memory wait. Drives stall/ID_EX_flush into the decode stage and PC/IF_ID write enables into fetch, and keeps saturating performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 28 ++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding,
// register-file constants and the wait-counter width.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WAIT_W = 16;

  localparam logic [REG_W-1:0] REG_X0 = REG_W'(0);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    ERR       = 2'd2
  } fsm_e;

  // Load in ID/EX writes a register the IF/ID instruction is about to read.
  function automatic logic load_use_hazard(
    input logic             memread,
    input logic [REG_W-1:0] wr_reg,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic             uses_rs2
  );
    return memread && (wr_reg != REG_X0) &&
           ((wr_reg == rs1) || (uses_rs2 && (wr_reg == rs2)));
  endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Central 5-stage pipeline sequencer: load-use stalls, branch flushes,
// fetch-miss bubbles, data-memory freeze with timeout, perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_rs1,
  input  logic [REG_W-1:0] IF_ID_rs2,
  input  logic             IF_ID_uses_rs2,
  input  logic             ID_EX_memread,
  input  logic [REG_W-1:0] ID_EX_wr_reg,
  input  logic             EX_branch_taken,
  input  logic             EX_MEM_memreq,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             stall,
  output logic             ID_EX_flush,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fsm_e              state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              load_use;
  logic              front_active;
  logic              flush_evt;
  logic              stall_evt;

  assign load_use = load_use_hazard(ID_EX_memread, ID_EX_wr_reg, IF_ID_rs1,
                                    IF_ID_rs2, IF_ID_uses_rs2);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state and zero-latency pipeline controls
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    stall        = 1'b0;
    ID_EX_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    flush_evt    = 1'b0;
    front_active = 1'b0;

    unique case (state)
      RUN: begin
        if (EX_MEM_memreq && !dmem_ready) begin
          pipe_freeze  = 1'b1;
          state_nxt    = DMEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end else begin
          front_active = 1'b1;
        end
      end
      DMEM_WAIT: begin
        if (dmem_ready) begin
          front_active = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          pipe_freeze = 1'b1;
          if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state_nxt = ERR;
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      ERR: begin
        pipe_freeze = 1'b1;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    if (pipe_freeze) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
    end else if (front_active) begin
      // Redirect beats load-use and fetch miss: the younger work is discarded anyway
      if (EX_branch_taken) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        flush_evt   = 1'b1;
      end else if (load_use) begin
        stall       = 1'b1;
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
      end else if (!imem_ready) begin
        pc_write    = 1'b0;
        IF_ID_flush = 1'b1;
      end
    end

    if (rst) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b0;
      stall       = 1'b0;
      ID_EX_flush = 1'b0;
      pipe_freeze = 1'b0;
      flush_evt   = 1'b0;
    end
  end

  assign stall_evt = stall || pipe_freeze;

  // Sticky timeout flag, one cycle behind the ERR entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if (state == ERR) begin
      mem_err <= 1'b1;
    end
  end

  // Saturating stall/freeze counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Saturating taken-branch flush counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) begin
      flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a cycle-level
// reference model of the sequencing rules.
module tb_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CW      = 4;
  localparam int          CMAX    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    IF_ID_rs1 = '0, IF_ID_rs2 = '0, ID_EX_wr_reg = '0;
  logic          IF_ID_uses_rs2 = 1'b0, ID_EX_memread = 1'b0;
  logic          EX_branch_taken = 1'b0, EX_MEM_memreq = 1'b0;
  logic          dmem_ready = 1'b1, imem_ready = 1'b1;
  logic          pc_write, IF_ID_write, IF_ID_flush, stall, ID_EX_flush;
  logic          pipe_freeze, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_frozen, m_err, m_memerr;
  int m_n, m_stall, m_flush;
  bit e_pc, e_ifw, e_iff, e_st, e_idf, e_frz;

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_uses_rs2(IF_ID_uses_rs2),
    .ID_EX_memread(ID_EX_memread), .ID_EX_wr_reg(ID_EX_wr_reg),
    .EX_branch_taken(EX_branch_taken), .EX_MEM_memreq(EX_MEM_memreq),
    .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .stall(stall), .ID_EX_flush(ID_EX_flush), .pipe_freeze(pipe_freeze),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frozen = 0; m_err = 0; m_memerr = 0; m_n = 0; m_stall = 0; m_flush = 0;
  endtask

  // Reset asserted asynchronously; outputs and counters must clear at once
  task automatic do_reset();
    rst = 1'b1;
    EX_branch_taken = 0; ID_EX_memread = 0; EX_MEM_memreq = 0;
    IF_ID_uses_rs2 = 0; dmem_ready = 1; imem_ready = 1;
    #1;
    model_reset();
    chk("rst_pc_write", int'(pc_write), 0);
    chk("rst_if_id_write", int'(IF_ID_write), 0);
    chk("rst_freeze", int'(pipe_freeze), 0);
    chk("rst_ctrl_other", int'({IF_ID_flush, stall, ID_EX_flush}), 0);
    chk("rst_mem_err", int'(mem_err), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_flush_cnt", int'(flush_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive inputs, check combinational controls, clock, check registers
  task automatic step(input bit br, input bit mrd, input logic [4:0] wr,
                      input logic [4:0] rs1, input logic [4:0] rs2, input bit u2,
                      input bit mreq, input bit dr, input bit ir);
    bit lu, frz;
    EX_branch_taken = br; ID_EX_memread = mrd; ID_EX_wr_reg = wr;
    IF_ID_rs1 = rs1; IF_ID_rs2 = rs2; IF_ID_uses_rs2 = u2;
    EX_MEM_memreq = mreq; dmem_ready = dr; imem_ready = ir;
    #1;
    lu  = mrd && (wr != 0) && ((wr == rs1) || (u2 && (wr == rs2)));
    frz = m_err || (!dr && (m_frozen || mreq));
    e_pc = 1; e_ifw = 1; e_iff = 0; e_st = 0; e_idf = 0; e_frz = frz;
    if (frz) begin
      e_pc = 0; e_ifw = 0;
    end else if (br) begin
      e_iff = 1; e_idf = 1;
    end else if (lu) begin
      e_st = 1; e_pc = 0; e_ifw = 0;
    end else if (!ir) begin
      e_pc = 0; e_iff = 1;
    end
    chk("pc_write", int'(pc_write), int'(e_pc));
    chk("IF_ID_write", int'(IF_ID_write), int'(e_ifw));
    chk("IF_ID_flush", int'(IF_ID_flush), int'(e_iff));
    chk("stall", int'(stall), int'(e_st));
    chk("ID_EX_flush", int'(ID_EX_flush), int'(e_idf));
    chk("pipe_freeze", int'(pipe_freeze), int'(e_frz));
    @(posedge clk);
    if ((e_st || e_frz) && m_stall < CMAX) m_stall++;
    if (e_idf && m_flush < CMAX) m_flush++;
    m_memerr = m_memerr || m_err;
    if (!m_err) begin
      if (frz) begin
        m_n++;
        m_frozen = 1;
        if (m_n > int'(TIMEOUT)) m_err = 1;
      end else begin
        m_n = 0;
        m_frozen = 0;
      end
    end
    #1;
    chk("mem_err", int'(mem_err), int'(m_memerr));
    chk("stall_cnt", int'(stall_cnt), m_stall);
    chk("flush_cnt", int'(flush_cnt), m_flush);
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Load-use on rs1: one stall cycle, then the bubble clears it
    step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 1, 1);
    step(0, 0, 5'd5, 5'd5, 5'd0, 0, 0, 1, 1);
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    // Load to x0 never stalls; rs2 hazard only when rs2 is used
    step(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 1, 1);
    step(0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 1, 1);
    step(0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 1, 1);
    chk("lu_rs2_stall_cnt", int'(stall_cnt), 2);

    // Taken branch overrides load-use and fetch miss
    step(1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 1, 0);
    chk("br_flush_cnt", int'(flush_cnt), 1);
    chk("br_no_stall_cnt", int'(stall_cnt), 2);

    // Data-memory wait of three cycles, branch held until release
    do_reset();
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1);
    chk("dwait_stall_cnt", int'(stall_cnt), 3);
    chk("dwait_flush_cnt", int'(flush_cnt), 1);
    idle();

    // Two fetch misses with nothing else going on
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    idle();

    // Timeout into ERR; counter saturates while frozen
    do_reset();
    for (int i = 0; i < 24; i++) step(i % 3 == 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
    chk("err_sticky", int'(mem_err), 1);
    chk("err_stall_sat", int'(stall_cnt), CMAX);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);

    // Reset in the middle of a data-memory wait
    do_reset();
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
    do_reset();
    idle();
    chk("post_rst_pc_write", int'(pc_write), 1);

    // Flush counter saturation
    for (int i = 0; i < 20; i++) step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
    chk("flush_sat", int'(flush_cnt), CMAX);

    // Randomized traffic over a small register window to provoke hazards
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_err && ($urandom_range(0, 3) == 0)) do_reset();
      step($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
